theremin_period_averager: RTL and testbench



---
 rtl/theremin_period_averager.sv | 114 +++++++++++
 tb/tb_theremin_period_averager.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/theremin_period_averager.sv
// Moving sum over the last 2^AVG_LOG2 half-period measurements, with fill tracking
// and an inactivity watchdog that drops the window when the oscillator signal disappears.
module theremin_period_averager #(
  parameter int COUNTER_BITS = 12,
  parameter int AVG_LOG2     = 4,
  parameter int TIMEOUT_BITS = 12
) (
  input  logic                             CLK,
  input  logic                             RESETN,
  input  logic                             EDGE_FLAG,
  input  logic [COUNTER_BITS-1:0]          DURATION,
  output logic                             OUT_VALID,
  output logic [COUNTER_BITS+AVG_LOG2-1:0] PERIOD_SUM,
  output logic                             SIGNAL_OK,
  output logic [AVG_LOG2:0]                FILL_LEVEL
);

  localparam int SUM_W  = COUNTER_BITS + AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;
  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  // Timeout fires on the cycle the counter would reach all-ones.
  localparam logic [TIMEOUT_BITS-1:0] WDOG_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t                  state_reg;
  logic [AVG_LOG2-1:0]     wptr_reg;
  logic [SUM_W-1:0]        sum_reg;
  logic [TIMEOUT_BITS-1:0] wdog_reg;
  logic                    out_valid_reg;
  logic [SUM_W-1:0]        period_sum_reg;
  logic                    signal_ok_reg;
  logic [FILL_W-1:0]       fill_level_reg;

  logic [COUNTER_BITS-1:0] sample_mem [DEPTH];
  logic [COUNTER_BITS-1:0] old_sample;

  logic [SUM_W-1:0]  run_sum_next;
  logic [SUM_W-1:0]  fill_sum_next;
  logic [FILL_W-1:0] fill_level_next;

  // Asynchronous read gives the entry about to be overwritten in the same cycle.
  assign old_sample = sample_mem[wptr_reg];

  always_ff @(posedge CLK) begin
    if (RESETN && EDGE_FLAG) begin
      sample_mem[wptr_reg] <= DURATION;
    end
  end

  always_comb begin
    run_sum_next    = sum_reg + SUM_W'(DURATION) - SUM_W'(old_sample);
    fill_sum_next   = SUM_W'(DURATION);
    fill_level_next = FILL_W'(1);
    if (state_reg != IDLE) begin
      fill_sum_next   = sum_reg + SUM_W'(DURATION);
      fill_level_next = fill_level_reg + FILL_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_reg      <= IDLE;
      wptr_reg       <= '0;
      sum_reg        <= '0;
      wdog_reg       <= '0;
      out_valid_reg  <= 1'b0;
      period_sum_reg <= '0;
      signal_ok_reg  <= 1'b0;
      fill_level_reg <= '0;
    end else begin
      out_valid_reg <= 1'b0;
      if (EDGE_FLAG) begin
        wdog_reg <= '0;
        wptr_reg <= wptr_reg + 1'b1;
        if (state_reg == RUN) begin
          sum_reg        <= run_sum_next;
          period_sum_reg <= run_sum_next;
          out_valid_reg  <= 1'b1;
        end else begin
          sum_reg        <= fill_sum_next;
          fill_level_reg <= fill_level_next;
          if (fill_level_next == FILL_FULL) begin
            state_reg      <= RUN;
            period_sum_reg <= fill_sum_next;
            out_valid_reg  <= 1'b1;
            signal_ok_reg  <= 1'b1;
          end else begin
            state_reg <= FILL;
          end
        end
      end else if (state_reg != IDLE) begin
        if (wdog_reg == WDOG_LAST) begin
          state_reg      <= IDLE;
          wptr_reg       <= '0;
          sum_reg        <= '0;
          wdog_reg       <= '0;
          period_sum_reg <= '0;
          signal_ok_reg  <= 1'b0;
          fill_level_reg <= '0;
        end else begin
          wdog_reg <= wdog_reg + 1'b1;
        end
      end
    end
  end

  assign OUT_VALID  = out_valid_reg;
  assign PERIOD_SUM = period_sum_reg;
  assign SIGNAL_OK  = signal_ok_reg;
  assign FILL_LEVEL = fill_level_reg;

endmodule

// File: tb/tb_theremin_period_averager.sv
// Directed bench for theremin_period_averager: fill, steady/step, watchdog boundary,
// mid-operation reset and back-to-back strobes.
module tb_theremin_period_averager;

  logic        CLK;
  logic        RESETN;
  logic        EDGE_FLAG;
  logic [11:0] DURATION;
  logic        OUT_VALID;
  logic [15:0] PERIOD_SUM;
  logic        SIGNAL_OK;
  logic [4:0]  FILL_LEVEL;

  int checks   = 0;
  int failures = 0;
  int pulses;

  theremin_period_averager #(
    .COUNTER_BITS(12),
    .AVG_LOG2(4),
    .TIMEOUT_BITS(12)
  ) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .EDGE_FLAG(EDGE_FLAG),
    .DURATION(DURATION),
    .OUT_VALID(OUT_VALID),
    .PERIOD_SUM(PERIOD_SUM),
    .SIGNAL_OK(SIGNAL_OK),
    .FILL_LEVEL(FILL_LEVEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance past one rising edge and settle so outputs can be sampled safely.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic edge_in(input int d);
    EDGE_FLAG = 1'b1;
    DURATION  = 12'(d);
    tick();
    EDGE_FLAG = 1'b0;
    $display("edge duration=%0d out_valid=%0b period_sum=%0d signal_ok=%0b fill=%0d",
             d, OUT_VALID, PERIOD_SUM, SIGNAL_OK, FILL_LEVEL);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(OUT_VALID), 0);
    chk({tag, "_sum"}, 32'(PERIOD_SUM), 0);
    chk({tag, "_ok"}, 32'(SIGNAL_OK), 0);
    chk({tag, "_fill"}, 32'(FILL_LEVEL), 0);
  endtask

  initial begin
    RESETN    = 1'b0;
    EDGE_FLAG = 1'b0;
    DURATION  = 12'd77;

    // Reset held 3 cycles while strobes toggle
    for (int i = 0; i < 3; i++) begin
      EDGE_FLAG = (i % 2 == 0);
      tick();
      chk_zero("reset");
    end
    EDGE_FLAG = 1'b0;
    RESETN    = 1'b1;

    // Fill with 16 x 100, five cycles apart
    for (int i = 1; i <= 16; i++) begin
      edge_in(100);
      chk("fill_level", 32'(FILL_LEVEL), 32'(i));
      chk("fill_valid", 32'(OUT_VALID), (i == 16) ? 1 : 0);
      chk("fill_sum", 32'(PERIOD_SUM), (i == 16) ? 1600 : 0);
      chk("fill_ok", 32'(SIGNAL_OK), (i == 16) ? 1 : 0);
      tick();
      chk("fill_gap_valid", 32'(OUT_VALID), 0);
      idle(3);
    end
    chk("fill_hold_sum", 32'(PERIOD_SUM), 1600);

    // Alternating 90/110: first pass replaces 100s, second pass is steady at 1600
    for (int i = 0; i < 32; i++) begin
      edge_in((i % 2 == 1) ? 110 : 90);
      chk("alt_valid", 32'(OUT_VALID), 1);
      chk("alt_sum", 32'(PERIOD_SUM), (i < 16 && i % 2 == 0) ? 1590 : 1600);
      tick();
      chk("alt_gap_valid", 32'(OUT_VALID), 0);
    end

    // Step to 200: replaces 90 (+110) then 110 (+90) alternately
    for (int j = 0; j < 16; j++) begin
      edge_in(200);
      chk("step_sum", 32'(PERIOD_SUM), 1600 + 100 * (j + 1) + ((j % 2 == 0) ? 10 : 0));
      chk("step_valid", 32'(OUT_VALID), 1);
      if (j < 15) tick();
    end
    chk("step_final", 32'(PERIOD_SUM), 3200);

    // Edge landing on the 4095th quiet cycle wins over the timeout
    idle(4094);
    chk("wd_pre_ok", 32'(SIGNAL_OK), 1);
    chk("wd_pre_sum", 32'(PERIOD_SUM), 3200);
    edge_in(300);
    chk("wd_edge_valid", 32'(OUT_VALID), 1);
    chk("wd_edge_sum", 32'(PERIOD_SUM), 3300);
    chk("wd_edge_ok", 32'(SIGNAL_OK), 1);
    chk("wd_edge_fill", 32'(FILL_LEVEL), 16);

    // Genuine timeout: 4095 quiet cycles
    idle(4094);
    chk("wd_almost_ok", 32'(SIGNAL_OK), 1);
    chk("wd_almost_fill", 32'(FILL_LEVEL), 16);
    tick();
    chk_zero("timeout");
    idle(5);
    chk_zero("idle_after_timeout");

    // Fresh fill after timeout, then reset after 8 edges
    for (int i = 1; i <= 8; i++) begin
      edge_in(30);
      chk("refill_level", 32'(FILL_LEVEL), 32'(i));
      chk("refill_sum", 32'(PERIOD_SUM), 0);
    end
    RESETN = 1'b0;
    tick();
    RESETN = 1'b1;
    chk_zero("mid_reset");

    for (int i = 1; i <= 16; i++) begin
      edge_in(50);
      chk("post_reset_valid", 32'(OUT_VALID), (i == 16) ? 1 : 0);
      chk("post_reset_fill", 32'(FILL_LEVEL), 32'(i));
      idle(2);
    end
    chk("post_reset_sum", 32'(PERIOD_SUM), 800);
    chk("post_reset_ok", 32'(SIGNAL_OK), 1);

    // Back-to-back strobes k=1..40 from a clean start; window sum = 16k-120
    RESETN = 1'b0;
    tick();
    RESETN = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      EDGE_FLAG = 1'b1;
      DURATION  = 12'(k);
      tick();
      $display("b2b k=%0d out_valid=%0b period_sum=%0d fill=%0d",
               k, OUT_VALID, PERIOD_SUM, FILL_LEVEL);
      if (OUT_VALID === 1'b1) pulses++;
      if (k < 16) begin
        chk("b2b_fill", 32'(FILL_LEVEL), 32'(k));
        chk("b2b_valid_low", 32'(OUT_VALID), 0);
      end else begin
        chk("b2b_sum", 32'(PERIOD_SUM), 32'(16 * k - 120));
      end
    end
    EDGE_FLAG = 1'b0;
    tick();
    chk("b2b_pulses", 32'(pulses), 25);
    chk("b2b_hold", 32'(PERIOD_SUM), 520);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
